// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder / sequencer.
package decoder_pkg;

  // Sequencer states; encoding is fixed so other logic can decode it directly.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Largest supported select width; 2^6 = 64 output lines.
  localparam int MAX_N = 6;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Decode of idx into a 2^n-bit one-hot vector, zero-extended to 64 bits.
  function automatic logic [63:0] onehot(input logic [5:0] idx, input int n);
    logic [63:0] mask;
    mask = (n >= MAX_N) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    return (64'd1 << idx) & mask;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-to-2^N line decoder with selectable output polarity.
module decoder_onehot #(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   lines
);

  localparam int   W   = 2**N;
  localparam logic POL = (ACTIVE_LOW != 0);

  // One comparator per line; polarity applied by XOR so the active line is
  // the only one that differs from its neighbours.
  for (genvar gi = 0; gi < W; gi++) begin : g_line
    localparam logic [N-1:0] LINE_IDX = N'(gi);
    assign lines[gi] = (sel == LINE_IDX) ^ POL;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with DIRECT (hold loaded index) and SCAN
// (walk all lines with a programmable dwell) modes.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int DWELL      = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      in,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      idx,
  output logic              valid,
  output logic              wrap
);

  localparam int W  = 2**N;
  // Counter is at least one bit wide even when DWELL = 1 (then it stays 0).
  localparam int CW = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};
  localparam logic [W-1:0]  OUT_IDLE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q,   idx_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            valid_q, valid_d;
  logic            wrap_q,  wrap_d;
  logic [W-1:0]    out_q,   out_d;
  logic [W-1:0]    dec_lines;

  // Decode the next index so out lands in the same edge as idx.
  decoder_onehot #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_decode (
    .sel   (idx_d),
    .lines (dec_lines)
  );

  // Next-state, index, dwell counter and output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;

    if (!en) begin
      // Disable wins over everything; idx is kept for when we resume.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = mode ? SCAN : DIRECT;
          cnt_d   = '0;
          if (load) idx_d = in;
        end
        DIRECT: begin
          if (load) idx_d = in;
          if (mode) begin
            state_d = SCAN;
            cnt_d   = '0;
          end
        end
        SCAN: begin
          if (!mode) begin
            // Leaving scan freezes idx (or takes a simultaneous load).
            state_d = DIRECT;
            cnt_d   = '0;
            if (load) idx_d = in;
          end else if (load) begin
            // A load restarts the dwell and pre-empts this edge's step.
            idx_d = in;
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = '0;
            wrap_d = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    valid_d = (state_d != IDLE);
    out_d   = valid_d ? dec_lines : OUT_IDLE;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      out_q   <= OUT_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign out   = out_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: three instances (N=2/DWELL=1,
// N=2/DWELL=3, N=3/ACTIVE_LOW=1) driven from shared control inputs.
module tb_decoder_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       load;
  logic [2:0] in3;

  logic [3:0] out_a;
  logic [1:0] idx_a;
  logic       valid_a, wrap_a;
  logic [3:0] out_b;
  logic [1:0] idx_b;
  logic       valid_b, wrap_b;
  logic [7:0] out_c;
  logic [2:0] idx_c;
  logic       valid_c, wrap_c;

  int errors = 0;
  int checks = 0;

  decoder_seq #(.N(2), .DWELL(1), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .in(in3[1:0]),
    .out(out_a), .idx(idx_a), .valid(valid_a), .wrap(wrap_a)
  );

  decoder_seq #(.N(2), .DWELL(3), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .in(in3[1:0]),
    .out(out_b), .idx(idx_b), .valid(valid_b), .wrap(wrap_b)
  );

  decoder_seq #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .in(in3),
    .out(out_c), .idx(idx_c), .valid(valid_c), .wrap(wrap_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       mode;
    logic       load;
    logic [1:0] in;
    logic [3:0] out;
    logic [1:0] idx;
    logic       valid;
    logic       wrap;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_b;

    // DUT A vectors: DIRECT load sweep, DIRECT->SCAN with load, wrap,
    // SCAN->DIRECT freeze, disable, and load ignored while disabled.
    //            en    mode  load  in     out      idx    valid wrap
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 4'b0000, 2'd1, 1'b0, 1'b0};

    // Reset held for three cycles.
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; in3 = 3'd0;
    repeat (3) step();
    chk("reset.out_a",   32'(out_a),   32'h0);
    chk("reset.idx_a",   32'(idx_a),   32'h0);
    chk("reset.valid_a", 32'(valid_a), 32'h0);
    chk("reset.wrap_a",  32'(wrap_a),  32'h0);
    chk("reset.out_c",   32'(out_c),   32'hff);
    rst_n = 1'b1;

    // Table-driven vectors against DUT A.
    for (int i = 0; i < 11; i++) begin
      en   = vecs[i].en;
      mode = vecs[i].mode;
      load = vecs[i].load;
      in3  = {1'b0, vecs[i].in};
      step();
      chk($sformatf("vec%0d.out",   i), 32'(out_a),   32'(vecs[i].out));
      chk($sformatf("vec%0d.idx",   i), 32'(idx_a),   32'(vecs[i].idx));
      chk($sformatf("vec%0d.valid", i), 32'(valid_a), 32'(vecs[i].valid));
      chk($sformatf("vec%0d.wrap",  i), 32'(wrap_a),  32'(vecs[i].wrap));
    end

    // Asynchronous reset in the middle of a scan, between clock edges.
    en = 1'b1; mode = 1'b1; load = 1'b1; in3 = 3'd2;
    step();
    load = 1'b0;
    step();
    step();
    chk("midscan.pre_valid_a", 32'(valid_a), 32'h1);
    chk("midscan.pre_idx_a",   32'(idx_a),   32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midscan.out_a",   32'(out_a),   32'h0);
    chk("midscan.idx_a",   32'(idx_a),   32'h0);
    chk("midscan.valid_a", 32'(valid_a), 32'h0);
    chk("midscan.out_b",   32'(out_b),   32'h0);
    chk("midscan.out_c",   32'(out_c),   32'hff);
    #2;
    rst_n = 1'b1;

    // Dwell on DUT B: each line held 3 cycles, wrap after 12.
    en = 1'b1; mode = 1'b1; load = 1'b1; in3 = 3'd0;
    step();
    load = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      exp_b = 4'b0001 << ((k / 3) % 4);
      chk($sformatf("dwell%0d.out_b",  k), 32'(out_b),  32'(exp_b));
      chk($sformatf("dwell%0d.wrap_b", k), 32'(wrap_b), (k == 12) ? 32'h1 : 32'h0);
    end

    // Run to idx=3 with the counter at its last value, then load pre-empts.
    repeat (11) step();
    chk("prio.pre_idx_b", 32'(idx_b), 32'h3);
    load = 1'b1; in3 = 3'd1;
    step();
    chk("prio.idx_b",  32'(idx_b),  32'h1);
    chk("prio.out_b",  32'(out_b),  32'h2);
    chk("prio.wrap_b", 32'(wrap_b), 32'h0);
    load = 1'b0; en = 1'b0;
    step();
    chk("disable.out_b",   32'(out_b),   32'h0);
    chk("disable.valid_b", 32'(valid_b), 32'h0);
    chk("disable.idx_b",   32'(idx_b),   32'h1);

    // Polarity on DUT C: idle is all ones, active line is the single zero.
    chk("pol.idle_out_c",   32'(out_c),   32'hff);
    chk("pol.idle_valid_c", 32'(valid_c), 32'h0);
    en = 1'b1; mode = 1'b0; load = 1'b1; in3 = 3'd5;
    step();
    chk("pol.out_c",   32'(out_c),   32'hdf);
    chk("pol.idx_c",   32'(idx_c),   32'h5);
    chk("pol.valid_c", 32'(valid_c), 32'h1);
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
